single_port_ram: RTL and testbench
==================================

SINGLE_PORT_RAM -- requirements
Module: single_port_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, address width of every port; memory depth is 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32, word width of every data port.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 addrN (N=1..16)  input  ADDR_WIDTH  word address of port N.
REQ-006 weN (N=1..16)  input  1  write enable of port N; 1 = write, 0 = read.
REQ-007 i_dataN (N=1..16)  input  DATA_WIDTH  write data of port N.
REQ-008 o_dataN (N=1..16)  output  DATA_WIDTH  registered read data of port N.

Function
REQ-009 The block SHALL hold one shared array of 2**ADDR_WIDTH words, each DATA_WIDTH bits, accessible through 16 independent ports.
REQ-010 On each rising clk edge with rst=0 and weN=1, port N SHALL write i_dataN to mem[addrN].
REQ-011 On each rising clk edge with rst=0, every port N SHALL load o_dataN with mem[addrN], regardless of weN; read latency is 1 cycle.
REQ-012 Read-during-write SHALL be read-first: o_dataN returns contents before that edge's writes, on any port, same address included.
REQ-013 Written data SHALL be visible to reads on all ports from the next edge onward.
REQ-014 When several ports write the same address on one edge, the lowest-numbered writing port SHALL win; the other writes to that address are discarded.
REQ-015 Writes from different ports to different addresses on one edge SHALL all take effect.
REQ-016 o_dataN SHALL hold its value between edges; outputs change only on rising clk.
REQ-017 Addresses SHALL be used unmodified (full range, no wrap or bounds logic needed since every ADDR_WIDTH value is valid).
REQ-018 Memory contents after power-up are undefined until written; reading unwritten words returns an unspecified value.

Reset
REQ-019 While rst=1 at a rising edge, all o_dataN SHALL become 0.
REQ-020 While rst=1, all writes SHALL be suppressed; memory contents SHALL be retained (array is not cleared).
REQ-021 Reset asserted mid-operation SHALL cancel only the writes of that edge; the first edge after rst falls SHALL behave per REQ-010..REQ-014.
REQ-022 If rst is left unconnected or non-1, the block SHALL operate normally (reset treated as inactive).

Structure
REQ-023 A shared package SHALL hold the default ADDR_WIDTH/DATA_WIDTH values and the port count constant (16).
REQ-024 One sub-module, ram_write_arbiter, SHALL resolve per-address write priority among the 16 ports; read path stays in the top module.
REQ-025 The memory array SHALL be inferable as RAM/registers by synthesis; no vendor primitives.

Verification
REQ-026 Port1 we1=1, addr1=0, i_data1=0x10 one edge; then we1=0, addr1=0 -> o_data1=0x00000010 one cycle later.
REQ-027 Port2 writes 0x11 to addr 2, port11 writes 0xAF to addr 7; then port5 reads addr 2 and port16 reads addr 7 -> 0x11 and 0xAF.
REQ-028 Same edge: port3 writes 0xAAAA to addr 0x0100, port9 writes 0x5555 to addr 0x0100 -> subsequent read of 0x0100 returns 0xAAAA.
REQ-029 Addr 4 holds 0x1; port1 writes 0x2 to addr 4 while port2 reads addr 4 same edge -> o_data2=0x1, next read returns 0x2.
REQ-030 rst=1 for 2 edges while we1=1, addr1=5, i_data1=0xFF -> all o_dataN=0, mem[5] unchanged; after rst=0 normal write/read resumes.
REQ-031 All 16 ports write distinct values to addresses 0..15 on one edge, then all read back swapped addresses -> every value correct, boundary addr 0xFFFF also writable/readable.

Source files
------------

// File: rtl/single_port_ram_pkg.sv
// Shared constants for the 16-port shared RAM.
// Default geometry and port count used by top and arbiter.
package single_port_ram_pkg;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_PORTS      = 16;
endpackage

// File: rtl/ram_write_arbiter.sv
// Per-address write priority among the RAM ports.
// A write is granted unless a lower-numbered port writes the same address.
module ram_write_arbiter
  import single_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [NUM_PORTS-1:0]                 we,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr,
  output logic [NUM_PORTS-1:0]                 grant
);

  always_comb begin
    grant = we;
    for (int n = 1; n < NUM_PORTS; n++) begin
      for (int m = 0; m < n; m++) begin
        if (we[m] && (addr[m] == addr[n]))
          grant[n] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/single_port_ram.sv
// Shared RAM with 16 independent read/write ports.
// Reads are registered and read-first; writes resolved by the arbiter.
module single_port_ram
  import single_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic [DATA_WIDTH-1:0] o_data1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic                  we2,
  input  logic [DATA_WIDTH-1:0] i_data2,
  output logic [DATA_WIDTH-1:0] o_data2,
  input  logic [ADDR_WIDTH-1:0] addr3,
  input  logic                  we3,
  input  logic [DATA_WIDTH-1:0] i_data3,
  output logic [DATA_WIDTH-1:0] o_data3,
  input  logic [ADDR_WIDTH-1:0] addr4,
  input  logic                  we4,
  input  logic [DATA_WIDTH-1:0] i_data4,
  output logic [DATA_WIDTH-1:0] o_data4,
  input  logic [ADDR_WIDTH-1:0] addr5,
  input  logic                  we5,
  input  logic [DATA_WIDTH-1:0] i_data5,
  output logic [DATA_WIDTH-1:0] o_data5,
  input  logic [ADDR_WIDTH-1:0] addr6,
  input  logic                  we6,
  input  logic [DATA_WIDTH-1:0] i_data6,
  output logic [DATA_WIDTH-1:0] o_data6,
  input  logic [ADDR_WIDTH-1:0] addr7,
  input  logic                  we7,
  input  logic [DATA_WIDTH-1:0] i_data7,
  output logic [DATA_WIDTH-1:0] o_data7,
  input  logic [ADDR_WIDTH-1:0] addr8,
  input  logic                  we8,
  input  logic [DATA_WIDTH-1:0] i_data8,
  output logic [DATA_WIDTH-1:0] o_data8,
  input  logic [ADDR_WIDTH-1:0] addr9,
  input  logic                  we9,
  input  logic [DATA_WIDTH-1:0] i_data9,
  output logic [DATA_WIDTH-1:0] o_data9,
  input  logic [ADDR_WIDTH-1:0] addr10,
  input  logic                  we10,
  input  logic [DATA_WIDTH-1:0] i_data10,
  output logic [DATA_WIDTH-1:0] o_data10,
  input  logic [ADDR_WIDTH-1:0] addr11,
  input  logic                  we11,
  input  logic [DATA_WIDTH-1:0] i_data11,
  output logic [DATA_WIDTH-1:0] o_data11,
  input  logic [ADDR_WIDTH-1:0] addr12,
  input  logic                  we12,
  input  logic [DATA_WIDTH-1:0] i_data12,
  output logic [DATA_WIDTH-1:0] o_data12,
  input  logic [ADDR_WIDTH-1:0] addr13,
  input  logic                  we13,
  input  logic [DATA_WIDTH-1:0] i_data13,
  output logic [DATA_WIDTH-1:0] o_data13,
  input  logic [ADDR_WIDTH-1:0] addr14,
  input  logic                  we14,
  input  logic [DATA_WIDTH-1:0] i_data14,
  output logic [DATA_WIDTH-1:0] o_data14,
  input  logic [ADDR_WIDTH-1:0] addr15,
  input  logic                  we15,
  input  logic [DATA_WIDTH-1:0] i_data15,
  output logic [DATA_WIDTH-1:0] o_data15,
  input  logic [ADDR_WIDTH-1:0] addr16,
  input  logic                  we16,
  input  logic [DATA_WIDTH-1:0] i_data16,
  output logic [DATA_WIDTH-1:0] o_data16
);

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;
  logic [NUM_PORTS-1:0]                 we;
  logic [NUM_PORTS-1:0]                 grant;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  assign addr = {addr16, addr15, addr14, addr13,
                 addr12, addr11, addr10, addr9,
                 addr8,  addr7,  addr6,  addr5,
                 addr4,  addr3,  addr2,  addr1};

  assign we = {we16, we15, we14, we13,
               we12, we11, we10, we9,
               we8,  we7,  we6,  we5,
               we4,  we3,  we2,  we1};

  assign wdata = {i_data16, i_data15, i_data14, i_data13,
                  i_data12, i_data11, i_data10, i_data9,
                  i_data8,  i_data7,  i_data6,  i_data5,
                  i_data4,  i_data3,  i_data2,  i_data1};

  assign {o_data16, o_data15, o_data14, o_data13,
          o_data12, o_data11, o_data10, o_data9,
          o_data8,  o_data7,  o_data6,  o_data5,
          o_data4,  o_data3,  o_data2,  o_data1} = rdata;

  ram_write_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_arb (
    .we   (we),
    .addr (addr),
    .grant(grant)
  );

  // Granted writes never share an address, so loop order is irrelevant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < NUM_PORTS; n++) begin
        if (grant[n])
          mem[addr[n]] <= wdata[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      for (int n = 0; n < NUM_PORTS; n++)
        rdata[n] <= mem[addr[n]];
    end
  end

endmodule

// File: tb/tb_single_port_ram.sv
// Directed and random checks of single_port_ram against a
// dictionary model of memory contents.
module tb_single_port_ram;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr   [NP];
  logic          we     [NP];
  logic [DW-1:0] i_data [NP];
  logic [DW-1:0] o_data [NP];

  logic [DW-1:0] mem_m [int];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  single_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .addr1(addr[0]),   .we1(we[0]),   .i_data1(i_data[0]),   .o_data1(o_data[0]),
    .addr2(addr[1]),   .we2(we[1]),   .i_data2(i_data[1]),   .o_data2(o_data[1]),
    .addr3(addr[2]),   .we3(we[2]),   .i_data3(i_data[2]),   .o_data3(o_data[2]),
    .addr4(addr[3]),   .we4(we[3]),   .i_data4(i_data[3]),   .o_data4(o_data[3]),
    .addr5(addr[4]),   .we5(we[4]),   .i_data5(i_data[4]),   .o_data5(o_data[4]),
    .addr6(addr[5]),   .we6(we[5]),   .i_data6(i_data[5]),   .o_data6(o_data[5]),
    .addr7(addr[6]),   .we7(we[6]),   .i_data7(i_data[6]),   .o_data7(o_data[6]),
    .addr8(addr[7]),   .we8(we[7]),   .i_data8(i_data[7]),   .o_data8(o_data[7]),
    .addr9(addr[8]),   .we9(we[8]),   .i_data9(i_data[8]),   .o_data9(o_data[8]),
    .addr10(addr[9]),  .we10(we[9]),  .i_data10(i_data[9]),  .o_data10(o_data[9]),
    .addr11(addr[10]), .we11(we[10]), .i_data11(i_data[10]), .o_data11(o_data[10]),
    .addr12(addr[11]), .we12(we[11]), .i_data12(i_data[11]), .o_data12(o_data[11]),
    .addr13(addr[12]), .we13(we[12]), .i_data13(i_data[12]), .o_data13(o_data[12]),
    .addr14(addr[13]), .we14(we[13]), .i_data14(i_data[13]), .o_data14(o_data[13]),
    .addr15(addr[14]), .we15(we[14]), .i_data15(i_data[14]), .o_data15(o_data[14]),
    .addr16(addr[15]), .we16(we[15]), .i_data16(i_data[15]), .o_data16(o_data[15])
  );

  task automatic idle();
    for (int n = 0; n < NP; n++) begin
      we[n] = 1'b0;
      addr[n] = '0;
      i_data[n] = '0;
    end
  endtask

  // Expected reads come from contents before this edge; writes then
  // apply in port order, first claimant of an address winning.
  task automatic step(string tag);
    logic [DW-1:0] exp [NP];
    bit known [NP];
    bit claimed [int];
    for (int n = 0; n < NP; n++) begin
      if (rst === 1'b1) begin
        exp[n] = '0;
        known[n] = 1'b1;
      end else if (mem_m.exists(int'(addr[n]))) begin
        exp[n] = mem_m[int'(addr[n])];
        known[n] = 1'b1;
      end else begin
        exp[n] = '0;
        known[n] = 1'b0;
      end
    end
    if (rst !== 1'b1) begin
      for (int n = 0; n < NP; n++) begin
        if (we[n] && !claimed.exists(int'(addr[n]))) begin
          claimed[int'(addr[n])] = 1'b1;
          mem_m[int'(addr[n])] = i_data[n];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < NP; n++) begin
      if (known[n]) begin
        checks++;
        assert (o_data[n] === exp[n]) else begin
          errors++;
          $error("FAIL %s port%0d: got %h expected %h",
                 tag, n + 1, o_data[n], exp[n]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step("reset");
    rst = 1'b0;

    // Port1 write then read addr 0
    we[0] = 1'b1; addr[0] = 16'h0000; i_data[0] = 32'h10;
    step("p1_write");
    idle();
    step("p1_read");

    // Port2 / port11 writes, port5 / port16 reads
    we[1] = 1'b1; addr[1] = 16'd2; i_data[1] = 32'h11;
    we[10] = 1'b1; addr[10] = 16'd7; i_data[10] = 32'hAF;
    step("p2_p11_write");
    idle();
    addr[4] = 16'd2; addr[15] = 16'd7;
    step("p5_p16_read");

    // Same-address collision: port3 beats port9
    idle();
    we[2] = 1'b1; addr[2] = 16'h0100; i_data[2] = 32'hAAAA;
    we[8] = 1'b1; addr[8] = 16'h0100; i_data[8] = 32'h5555;
    step("collide_write");
    idle();
    addr[0] = 16'h0100; addr[8] = 16'h0100;
    step("collide_read");

    // Read-during-write on addr 4
    idle();
    we[0] = 1'b1; addr[0] = 16'd4; i_data[0] = 32'h1;
    step("rdw_init");
    we[0] = 1'b1; addr[0] = 16'd4; i_data[0] = 32'h2;
    addr[1] = 16'd4;
    step("rdw_same_edge");
    idle();
    addr[1] = 16'd4;
    step("rdw_after");

    // Reset held with a pending write to addr 5
    idle();
    we[0] = 1'b1; addr[0] = 16'd5; i_data[0] = 32'h55;
    step("pre_rst_write");
    rst = 1'b1;
    we[0] = 1'b1; addr[0] = 16'd5; i_data[0] = 32'hFF;
    step("rst_edge1");
    step("rst_edge2");
    rst = 1'b0;
    idle();
    addr[0] = 16'd5; addr[6] = 16'd5;
    step("post_rst_read");
    we[0] = 1'b1; addr[0] = 16'd5; i_data[0] = 32'h77;
    step("post_rst_write");
    idle();
    addr[3] = 16'd5;
    step("post_rst_readback");

    // All ports write 0..15, then read swapped; plus top address
    for (int n = 0; n < NP; n++) begin
      we[n] = 1'b1;
      addr[n] = AW'(n);
      i_data[n] = 32'hC0DE_0000 + 32'(n * 17);
    end
    step("all_write");
    idle();
    for (int n = 0; n < NP; n++)
      addr[n] = AW'(NP - 1 - n);
    step("all_read_swapped");
    idle();
    we[15] = 1'b1; addr[15] = 16'hFFFF; i_data[15] = 32'hDEAD_BEEF;
    step("top_write");
    idle();
    addr[0] = 16'hFFFF; addr[15] = 16'hFFFF;
    step("top_read");

    // Random traffic over a small address pool to force collisions
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 24) == 0);
      for (int n = 0; n < NP; n++) begin
        we[n] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0)
          addr[n] = 16'hFFFF;
        else
          addr[n] = AW'($urandom_range(0, 23));
        i_data[n] = $urandom;
      end
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
